// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared state encodings, defaults and helpers for the CPU-to-peripheral bridge
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F00;
  localparam int          HWINT_W       = 6;

  // A single-device build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_decoder.sv
// rtl/bridge_decoder.sv - combinational CPU address to device window decode (hit, index, one-hot)
module bridge_decoder
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV         = 2,
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int unsigned DEV_STRIDE_LOG2 = 4,
  parameter int          IDX_W           = idx_width(NUM_DEV)
) (
  input  logic [31:0]        addr,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_DEV-1:0] onehot
);

  logic [31:0] win;

  // Window number relative to device 0; wraps huge for addresses below the base,
  // which the explicit lower-bound compare rejects anyway.
  assign win = (addr >> DEV_STRIDE_LOG2) - (BASE_ADDR >> DEV_STRIDE_LOG2);
  assign hit = (addr >= BASE_ADDR) && (win < 32'(NUM_DEV));
  assign idx = win[IDX_W-1:0];

  always_comb begin
    onehot = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      if (hit && (win == 32'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/sys_bridge.sv
// rtl/sys_bridge.sv - CPU-to-peripheral bridge with wait-state handshake; optional BRIDGE_TIMEOUT_EN bus timeout
module sys_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned NUM_DEV         = 2,
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int unsigned DEV_STRIDE_LOG2 = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [3:0]                   cpu_be,
  input  logic [31:0]                  cpu_addr,
  input  logic [31:0]                  cpu_wd,
  output logic [31:0]                  cpu_rd,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic                         cpu_busy,
  output logic [NUM_DEV-1:0]           dev_sel,
  output logic [NUM_DEV-1:0]           dev_we,
  output logic [DEV_STRIDE_LOG2-3:0]   dev_addr,
  output logic [3:0]                   dev_be,
  output logic [31:0]                  dev_wd,
  input  logic [NUM_DEV*32-1:0]        dev_rd,
  input  logic [NUM_DEV-1:0]           dev_ack,
  input  logic [NUM_DEV-1:0]           dev_irq,
  output logic [HWINT_W-1:0]           hwint
);

  localparam int IDX_W = idx_width(NUM_DEV);

  state_t               state, state_next;
  logic                 dec_hit;
  logic [IDX_W-1:0]     dec_idx;
  logic [NUM_DEV-1:0]   dec_onehot;

  logic                 we_l;
  logic [IDX_W-1:0]     idx_l;
  logic [NUM_DEV-1:0]   sel_l;
  logic                 ack_sel;
  logic                 timeout;
  logic [31:0]          rd_mux;
  logic [HWINT_W-1:0]   irq_ext;

  bridge_decoder #(
    .NUM_DEV         (NUM_DEV),
    .BASE_ADDR       (BASE_ADDR),
    .DEV_STRIDE_LOG2 (DEV_STRIDE_LOG2),
    .IDX_W           (IDX_W)
  ) u_decoder (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  // Acks from devices other than the latched target never reach the FSM.
  assign ack_sel = |(dev_ack & sel_l);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < int'(NUM_DEV); i++) begin
      if (32'(i) == 32'(idx_l)) rd_mux = dev_rd[32*i +: 32];
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Held at zero while idle so every ACCESS starts counting from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != ST_ACCESS) begin
      to_cnt <= '0;
    end else if (!ack_sel) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = (state == ST_ACCESS) && !ack_sel && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cpu_req) state_next = dec_hit ? ST_ACCESS : ST_RESP;
      end
      ST_ACCESS: begin
        if (ack_sel || timeout) state_next = ST_RESP;
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_l     <= 1'b0;
      idx_l    <= '0;
      sel_l    <= '0;
      dev_addr <= '0;
      dev_be   <= '0;
      dev_wd   <= '0;
      cpu_rd   <= '0;
      cpu_err  <= 1'b0;
    end else begin
      if (state == ST_IDLE && cpu_req) begin
        we_l     <= cpu_we;
        idx_l    <= dec_idx;
        sel_l    <= dec_onehot;
        dev_addr <= cpu_addr[DEV_STRIDE_LOG2-1:2];
        dev_be   <= cpu_be;
        dev_wd   <= cpu_wd;
        cpu_rd   <= '0;
        cpu_err  <= !dec_hit;
      end else if (state == ST_ACCESS) begin
        if (ack_sel) begin
          cpu_rd  <= we_l ? 32'd0 : rd_mux;
          cpu_err <= 1'b0;
        end else if (timeout) begin
          cpu_rd  <= '0;
          cpu_err <= 1'b1;
        end
      end
    end
  end

  assign dev_sel   = (state == ST_ACCESS) ? sel_l : '0;
  assign dev_we    = dev_sel & {NUM_DEV{we_l}};
  assign cpu_ready = (state == ST_RESP);
  assign cpu_busy  = (state != ST_IDLE);

  always_comb begin
    irq_ext              = '0;
    irq_ext[NUM_DEV-1:0] = dev_irq;
  end

  always_ff @(posedge clk) begin
    if (reset) hwint <= '0;
    else       hwint <= irq_ext;
  end

endmodule
